ldtu_frame_trailer: RTL and testbench

LDTU_FRAME_TRAILER -- requirements
Module: ldtu_frame_trailer

---
 rtl/ldtu_pkg.sv | 16 +
 rtl/ldtu_frame_trailer_if.sv | 33 +++
 rtl/ldtu_crc12.sv | 26 ++
 rtl/ldtu_frame_trailer.sv | 91 +++++++++
 tb/tb_ldtu_frame_trailer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ldtu_pkg.sv
// Shared constants and types for the LDTU frame trailer block.
// Compile-time option: LDTU_TRAILER_CRC_EN enables the CRC12 field in the trailer.
package ldtu_pkg;

    localparam logic [31:0] IDLE_PATTERN_EA = 32'hEAAAAAAA;
    localparam logic [31:0] IDLE_PATTERN_5A = 32'h5A5A5A5A;
    localparam logic [3:0]  TRAILER_HDR     = 4'hD;
    localparam logic [11:0] CRC12_POLY      = 12'h80F;

    // Frame assembly FSM: FILL streams FIFO words, TRAILER closes the frame.
    typedef enum logic {
        FILL    = 1'b0,
        TRAILER = 1'b1
    } trailer_state_t;

endpackage

// File: rtl/ldtu_frame_trailer_if.sv
// Bundle of the FIFO-side and stream-side signals of the frame trailer block.
// master: the trailer block itself (pops the FIFO, drives the stream).
// slave:  the surrounding environment (FIFO + downstream mux).
interface ldtu_frame_trailer_if #(
    parameter int Nbits_32 = 32
) ();

    logic                CALIBRATION_BUSY;
    logic                FIFO_EMPTY;
    logic [31:0]         FIFO_DATA;
    logic                FIFO_RD;
    logic [Nbits_32-1:0] DATA32_DTU;
    logic [7:0]          FRAME_CNT;

    modport master (
        input  CALIBRATION_BUSY,
        input  FIFO_EMPTY,
        input  FIFO_DATA,
        output FIFO_RD,
        output DATA32_DTU,
        output FRAME_CNT
    );

    modport slave (
        output CALIBRATION_BUSY,
        output FIFO_EMPTY,
        output FIFO_DATA,
        input  FIFO_RD,
        input  DATA32_DTU,
        input  FRAME_CNT
    );

endinterface

// File: rtl/ldtu_crc12.sv
// Combinational CRC12 (poly 0x80F) advance over one 32-bit word, MSB first.
// Only instantiated when LDTU_TRAILER_CRC_EN is defined.
module ldtu_crc12
    import ldtu_pkg::*;
(
    input  logic [11:0] crc_in,
    input  logic [31:0] data,
    output logic [11:0] crc_out
);

    logic [11:0] crc_work;

    // Unrolled bit-serial LFSR: 32 shift steps collapse into one cycle of logic.
    always_comb begin
        crc_work = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (crc_work[11] ^ data[i]) begin
                crc_work = {crc_work[10:0], 1'b0} ^ CRC12_POLY;
            end else begin
                crc_work = {crc_work[10:0], 1'b0};
            end
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/ldtu_frame_trailer.sv
// LDTU frame trailer: packs FRAME_WORDS FIFO words into a frame followed by a
// one-cycle trailer {hdr, frame number, word count, crc12}. Idle pattern is
// emitted whenever no word is popped.
// Compile-time option: LDTU_TRAILER_CRC_EN puts the running CRC12 into
// trailer bits [11:0]; without it those bits are zero and no CRC logic exists.
module ldtu_frame_trailer
    import ldtu_pkg::*;
#(
    parameter int FRAME_WORDS = 50,
    parameter int Nbits_32    = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    ldtu_frame_trailer_if.master bus
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_WORDS - 1);

    trailer_state_t      state_reg;
    logic [7:0]          word_cnt_reg;
    logic [7:0]          frame_num_reg;
    logic [Nbits_32-1:0] data_reg;
    logic [11:0]         crc_field;
    logic                rd;

    // Pop only while filling, data available, calibration idle, and out of reset.
    assign rd = RST && (state_reg == FILL) && !bus.FIFO_EMPTY && !bus.CALIBRATION_BUSY;

`ifdef LDTU_TRAILER_CRC_EN
    logic [11:0] crc_reg;
    logic [11:0] crc_next;

    ldtu_crc12 u_crc12 (
        .crc_in  (crc_reg),
        .data    (bus.FIFO_DATA),
        .crc_out (crc_next)
    );

    assign crc_field = crc_reg;

    // Running CRC: advanced on each pop, cleared as the trailer goes out.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            crc_reg <= 12'h000;
        end else if (state_reg == TRAILER) begin
            crc_reg <= 12'h000;
        end else if (rd) begin
            crc_reg <= crc_next;
        end
    end
`else
    assign crc_field = 12'h000;
`endif

    // Frame FSM with registered stream output, word counter and frame counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg     <= FILL;
            word_cnt_reg  <= 8'd0;
            frame_num_reg <= 8'd0;
            data_reg      <= Nbits_32'(IDLE_PATTERN_EA);
        end else begin
            unique case (state_reg)
                FILL: begin
                    if (rd) begin
                        data_reg     <= Nbits_32'(bus.FIFO_DATA);
                        word_cnt_reg <= word_cnt_reg + 8'd1;
                        if (word_cnt_reg == LAST_IDX) begin
                            state_reg <= TRAILER;
                        end
                    end else begin
                        data_reg <= Nbits_32'(IDLE_PATTERN_EA);
                    end
                end
                TRAILER: begin
                    // Trailer reports the completed count before clearing it.
                    data_reg      <= Nbits_32'({TRAILER_HDR, frame_num_reg, word_cnt_reg, crc_field});
                    word_cnt_reg  <= 8'd0;
                    frame_num_reg <= frame_num_reg + 8'd1;
                    state_reg     <= FILL;
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    assign bus.FIFO_RD    = rd;
    assign bus.DATA32_DTU = data_reg;
    assign bus.FRAME_CNT  = frame_num_reg;

endmodule

// File: tb/tb_ldtu_frame_trailer.sv
// Scoreboard bench for ldtu_frame_trailer: two instances (4-word and 1-word
// frames). Stimulus pushes hand-derived expectations per cycle; a monitor
// pops and compares FIFO_RD (pre-edge), DATA32_DTU and FRAME_CNT (post-edge).
module tb_ldtu_frame_trailer;

    localparam logic [31:0] IDLE = 32'hEAAAAAAA;

    typedef struct {
        logic        which;   // 0: 4-word instance, 1: 1-word instance
        logic        rd;
        logic [31:0] out;
        logic [7:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_val = 1'b0;
    exp_t q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clk = ~clk;

    ldtu_frame_trailer_if bus_a ();
    ldtu_frame_trailer_if bus_b ();

    ldtu_frame_trailer #(.FRAME_WORDS(4), .Nbits_32(32)) dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (bus_a.master)
    );

    ldtu_frame_trailer #(.FRAME_WORDS(1), .Nbits_32(32)) dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (bus_b.master)
    );

    // Reference CRC12, poly 0x80F, MSB first.
    function automatic logic [11:0] crc_word(input logic [11:0] c, input logic [31:0] d);
        logic [11:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            if (r[11] ^ d[i]) r = {r[10:0], 1'b0} ^ 12'h80F;
            else              r = {r[10:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [11:0] exp_crc4(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2, input logic [31:0] w3);
`ifdef LDTU_TRAILER_CRC_EN
        return crc_word(crc_word(crc_word(crc_word(12'h000, w0), w1), w2), w3);
`else
        return 12'h000;
`endif
    endfunction

    function automatic logic [31:0] trl(input logic [7:0] fnum, input logic [7:0] wc, input logic [11:0] crc);
        return {4'hD, fnum, wc, crc};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, idx, got, exp);
    endtask

    // One cycle on instance A with its expected response.
    task automatic cyc(input logic busy, input logic empty, input logic [31:0] data,
                       input logic erd, input logic [31:0] eout, input logic [7:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst = rst_val;
        bus_a.CALIBRATION_BUSY = busy;
        bus_a.FIFO_EMPTY       = empty;
        bus_a.FIFO_DATA        = data;
        e.which = 1'b0; e.rd = erd; e.out = eout; e.cnt = ecnt;
        q.push_back(e);
    endtask

    // One cycle on instance B (instance A held idle).
    task automatic cyc_b(input logic empty, input logic [31:0] data,
                         input logic erd, input logic [31:0] eout, input logic [7:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst = rst_val;
        bus_a.CALIBRATION_BUSY = 1'b0;
        bus_a.FIFO_EMPTY       = 1'b1;
        bus_b.CALIBRATION_BUSY = 1'b0;
        bus_b.FIFO_EMPTY       = empty;
        bus_b.FIFO_DATA        = data;
        e.which = 1'b1; e.rd = erd; e.out = eout; e.cnt = ecnt;
        q.push_back(e);
    endtask

    // Four back-to-back pops w..w+3, then the trailer cycle with w+4 at the FIFO head.
    task automatic frame4(input logic [31:0] w, input logic [7:0] fnum);
        logic [7:0] nxt;
        nxt = fnum + 8'd1;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, w + 32'(k), 1'b1, w + 32'(k), fnum);
        end
        cyc(1'b0, 1'b0, w + 32'd4, 1'b0,
            trl(fnum, 8'd4, exp_crc4(w, w + 32'd1, w + 32'd2, w + 32'd3)), nxt);
    endtask

    // Monitor: FIFO_RD sampled before the edge, stream/count after it.
    initial begin
        exp_t e;
        logic rd_s;
        int   idx;
        idx = 0;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                rd_s = e.which ? bus_b.FIFO_RD : bus_a.FIFO_RD;
                @(posedge clk);
                #2;
                chk(e.which ? "rd_b" : "rd_a", idx, 32'(rd_s), 32'(e.rd));
                chk(e.which ? "data_b" : "data_a", idx,
                    e.which ? bus_b.DATA32_DTU : bus_a.DATA32_DTU, e.out);
                chk(e.which ? "frame_cnt_b" : "frame_cnt_a", idx,
                    32'(e.which ? bus_b.FRAME_CNT : bus_a.FRAME_CNT), 32'(e.cnt));
                idx++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] b_crc;
`ifdef LDTU_TRAILER_CRC_EN
        b_crc = 12'h80F;
`else
        b_crc = 12'h000;
`endif
        bus_a.CALIBRATION_BUSY = 1'b0; bus_a.FIFO_EMPTY = 1'b1; bus_a.FIFO_DATA = 32'h0;
        bus_b.CALIBRATION_BUSY = 1'b0; bus_b.FIFO_EMPTY = 1'b1; bus_b.FIFO_DATA = 32'h0;

        // In reset with a non-empty FIFO: no pop, idle, count 0.
        rst_val = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 32'h12345678, 1'b0, IDLE, 8'd0);
        rst_val = 1'b1;

        // Empty FIFO after reset: idle stream.
        repeat (10) cyc(1'b0, 1'b1, 32'h0, 1'b0, IDLE, 8'd0);

        // Continuous FIFO: 1..4, trailer, 5..8, trailer.
        frame4(32'd1, 8'd0);
        frame4(32'd5, 8'd1);

        // Calibration busy for 3 cycles after word 2, plus an empty gap.
        cyc(1'b0, 1'b0, 32'd9,  1'b1, 32'd9,  8'd2);
        cyc(1'b0, 1'b0, 32'd10, 1'b1, 32'd10, 8'd2);
        repeat (3) cyc(1'b1, 1'b0, 32'd11, 1'b0, IDLE, 8'd2);
        cyc(1'b0, 1'b1, 32'd11, 1'b0, IDLE, 8'd2);
        cyc(1'b0, 1'b0, 32'd11, 1'b1, 32'd11, 8'd2);
        cyc(1'b0, 1'b0, 32'd12, 1'b1, 32'd12, 8'd2);
        cyc(1'b0, 1'b0, 32'd13, 1'b0, trl(8'd2, 8'd4, exp_crc4(32'd9, 32'd10, 32'd11, 32'd12)), 8'd3);

        // Idle pattern as data passes through; busy on the trailer cycle still gives a trailer.
        cyc(1'b0, 1'b0, 32'd13, 1'b1, 32'd13, 8'd3);
        cyc(1'b0, 1'b0, IDLE,   1'b1, IDLE,   8'd3);
        cyc(1'b0, 1'b0, 32'd15, 1'b1, 32'd15, 8'd3);
        cyc(1'b0, 1'b0, 32'd16, 1'b1, 32'd16, 8'd3);
        cyc(1'b1, 1'b0, 32'd17, 1'b0, trl(8'd3, 8'd4, exp_crc4(32'd13, IDLE, 32'd15, 32'd16)), 8'd4);
        cyc(1'b1, 1'b0, 32'd17, 1'b0, IDLE, 8'd4);
        cyc(1'b0, 1'b1, 32'd0,  1'b0, IDLE, 8'd4);

        // Reset after 2 of 4 words: partial frame discarded.
        cyc(1'b0, 1'b0, 32'd20, 1'b1, 32'd20, 8'd4);
        cyc(1'b0, 1'b0, 32'd21, 1'b1, 32'd21, 8'd4);
        rst_val = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 32'd22, 1'b0, IDLE, 8'd0);
        rst_val = 1'b1;

        // 257 frames from reset: frame_num 0 first, count wraps, 257th trailer numbered 0.
        for (int f = 0; f <= 256; f++) begin
            frame4(32'h100 + 32'(4 * f), 8'(f));
        end
        cyc(1'b0, 1'b1, 32'd0, 1'b0, IDLE, 8'd1);

        // One-word frames: CRC of 0x00000001.
        cyc_b(1'b0, 32'h00000001, 1'b1, 32'h00000001, 8'd0);
        cyc_b(1'b0, 32'h0000CAFE, 1'b0, trl(8'h00, 8'h01, b_crc), 8'd1);
        cyc_b(1'b1, 32'h0, 1'b0, IDLE, 8'd1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("scoreboard_drain", 0, 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
